// File: rtl/pll_reset_sequencer.sv
// -----------------------------------------------------------------------------
// pll_reset_sequencer
//
// Purpose:
//   Sits downstream of the PLL wrapper and runs on the PLL output clock. It
//   synchronises the PLL lock flag and requires it to stay high for a
//   programmable number of cycles. It then releases an active-low reset to the
//   display pipeline and raises ready after a further holdoff. While in
//   service, it filters lock dropouts. A real loss of lock re-sequences the
//   reset and is counted in a saturating event counter.
//
// Configuration macro:
//   PLL_LOSS_RECOVERY_EN - when defined, lock loss in HOLDOFF/RUN is filtered,
//                          enters FAULT and is counted. When undefined,
//                          lock_s is ignored once HOLDOFF is reached, FAULT is
//                          never entered and lost_count stays 0.
//
// Ports:
//   clk         in   PLL output clock; every flop lives in this domain
//   reset_n     in   asynchronous active-low reset
//   pll_locked  in   PLL lock flag, asynchronous to clk
//   rst_out_n   out  downstream reset, active-low (async assert, sync release)
//   ready       out  high once downstream is out of reset and past holdoff
//   seq_state   out  current FSM state (0 WAIT_LOCK, 1 QUALIFY, 2 HOLDOFF,
//                    3 RUN, 4 FAULT)
//   lost_count  out  saturating count of lock-loss events
// -----------------------------------------------------------------------------
module pll_reset_sequencer #(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int HOLDOFF_CYCLES     = 16,
  parameter int LOSS_FILTER_CYCLES = 4,
  parameter int LOST_CNT_W         = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  pll_locked,
  output logic                  rst_out_n,
  output logic                  ready,
  output logic [2:0]            seq_state,
  output logic [LOST_CNT_W-1:0] lost_count
);

  localparam int QUAL_W = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int HOLD_W = $clog2(HOLDOFF_CYCLES + 1);
  localparam int LOSS_W = $clog2(LOSS_FILTER_CYCLES + 1);

  localparam logic [QUAL_W-1:0]     QUAL_ZERO = {QUAL_W{1'b0}};
  localparam logic [QUAL_W-1:0]     QUAL_ONE  = QUAL_W'(32'd1);
  localparam logic [QUAL_W-1:0]     QUAL_LAST = QUAL_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [HOLD_W-1:0]     HOLD_ZERO = {HOLD_W{1'b0}};
  localparam logic [HOLD_W-1:0]     HOLD_ONE  = HOLD_W'(32'd1);
  localparam logic [HOLD_W-1:0]     HOLD_LAST = HOLD_W'(HOLDOFF_CYCLES - 1);
  localparam logic [LOSS_W-1:0]     LOSS_ZERO = {LOSS_W{1'b0}};
  localparam logic [LOSS_W-1:0]     LOSS_ONE  = LOSS_W'(32'd1);
  localparam logic [LOSS_W-1:0]     LOSS_LAST = LOSS_W'(LOSS_FILTER_CYCLES - 1);
  localparam logic [LOST_CNT_W-1:0] LOST_ZERO = {LOST_CNT_W{1'b0}};
  localparam logic [LOST_CNT_W-1:0] LOST_ONE  = LOST_CNT_W'(32'd1);
  localparam logic [LOST_CNT_W-1:0] LOST_MAX  = {LOST_CNT_W{1'b1}};

`ifdef PLL_LOSS_RECOVERY_EN
  localparam logic LOSS_RECOVERY = 1'b1;
`else
  // The filter counter still runs, but it can never raise a fault.
  localparam logic LOSS_RECOVERY = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_QUALIFY   = 3'd1,
    ST_HOLDOFF   = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_t;

  // Saturating increment for the lock-loss event counter (never wraps).
  function automatic logic [LOST_CNT_W-1:0] sat_inc(input logic [LOST_CNT_W-1:0] val);
    logic [LOST_CNT_W-1:0] res;
    if (val == LOST_MAX) begin
      res = val;
    end else begin
      res = val + LOST_ONE;
    end
    return res;
  endfunction

  logic                  r_sync1;
  logic                  r_lock_s;
  state_t                r_state;
  logic [QUAL_W-1:0]     r_qual_cnt;
  logic [HOLD_W-1:0]     r_hold_cnt;
  logic [LOSS_W-1:0]     r_loss_cnt;
  logic [LOST_CNT_W-1:0] r_lost_count;
  logic                  r_rst_out_n;
  logic                  r_ready;

  state_t                w_state_nxt;
  logic [QUAL_W-1:0]     w_qual_nxt;
  logic [HOLD_W-1:0]     w_hold_nxt;
  logic [LOSS_W-1:0]     w_loss_nxt;
  logic [LOST_CNT_W-1:0] w_lost_nxt;
  logic                  w_loss_hit;
  logic                  w_rst_out_n_nxt;
  logic                  w_ready_nxt;

  // Two-flop synchroniser for the asynchronous PLL lock flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1  <= 1'b0;
      r_lock_s <= 1'b0;
    end else begin
      r_sync1  <= pll_locked;
      r_lock_s <= r_sync1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_WAIT_LOCK;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, counter and output-decode logic.
  always_comb begin
    w_state_nxt = r_state;
    w_qual_nxt  = r_qual_cnt;
    w_hold_nxt  = r_hold_cnt;
    w_loss_nxt  = r_loss_cnt;
    w_lost_nxt  = r_lost_count;
    w_loss_hit  = 1'b0;

    case (r_state)
      ST_WAIT_LOCK: begin
        w_hold_nxt = HOLD_ZERO;
        w_loss_nxt = LOSS_ZERO;
        if (r_lock_s) begin
          // The sample that leaves WAIT_LOCK is the first of the stable window.
          w_state_nxt = ST_QUALIFY;
          w_qual_nxt  = QUAL_ONE;
        end else begin
          w_state_nxt = ST_WAIT_LOCK;
          w_qual_nxt  = QUAL_ZERO;
        end
      end

      ST_QUALIFY: begin
        if (!r_lock_s) begin
          // Loss wins even on what would have been the releasing edge.
          w_state_nxt = ST_WAIT_LOCK;
          w_qual_nxt  = QUAL_ZERO;
        end else if (r_qual_cnt >= QUAL_LAST) begin
          w_state_nxt = ST_HOLDOFF;
          w_qual_nxt  = QUAL_ZERO;
          w_hold_nxt  = HOLD_ZERO;
          w_loss_nxt  = LOSS_ZERO;
        end else begin
          w_qual_nxt  = r_qual_cnt + QUAL_ONE;
        end
      end

      ST_HOLDOFF, ST_RUN: begin
        // A dropout shorter than the filter length is ignored.
        if (r_lock_s) begin
          w_loss_nxt = LOSS_ZERO;
        end else if (r_loss_cnt == LOSS_LAST) begin
          w_loss_hit = LOSS_RECOVERY;
          w_loss_nxt = r_loss_cnt;
        end else begin
          w_loss_nxt = r_loss_cnt + LOSS_ONE;
        end

        if (w_loss_hit) begin
          // Loss takes priority over the HOLDOFF->RUN step.
          w_state_nxt = ST_FAULT;
          w_lost_nxt  = sat_inc(r_lost_count);
          w_loss_nxt  = LOSS_ZERO;
          w_hold_nxt  = HOLD_ZERO;
        end else if (r_state == ST_HOLDOFF) begin
          if (r_hold_cnt == HOLD_LAST) begin
            w_state_nxt = ST_RUN;
            w_hold_nxt  = HOLD_ZERO;
          end else begin
            w_state_nxt = ST_HOLDOFF;
            w_hold_nxt  = r_hold_cnt + HOLD_ONE;
          end
        end else begin
          w_state_nxt = ST_RUN;
        end
      end

      ST_FAULT: begin
        w_state_nxt = ST_WAIT_LOCK;
        w_qual_nxt  = QUAL_ZERO;
        w_hold_nxt  = HOLD_ZERO;
        w_loss_nxt  = LOSS_ZERO;
      end

      default: begin
        // Unused encodings 5..7 recover to WAIT_LOCK on the next edge.
        w_state_nxt = ST_WAIT_LOCK;
        w_qual_nxt  = QUAL_ZERO;
        w_hold_nxt  = HOLD_ZERO;
        w_loss_nxt  = LOSS_ZERO;
      end
    endcase

    // Outputs are decoded from the next state so the registered copies
    // change on the same edge as the state.
    w_rst_out_n_nxt = (w_state_nxt == ST_HOLDOFF) || (w_state_nxt == ST_RUN);
    w_ready_nxt     = (w_state_nxt == ST_RUN);
  end

  // Sequencing counters, event counter and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_qual_cnt   <= QUAL_ZERO;
      r_hold_cnt   <= HOLD_ZERO;
      r_loss_cnt   <= LOSS_ZERO;
      r_lost_count <= LOST_ZERO;
      r_rst_out_n  <= 1'b0;
      r_ready      <= 1'b0;
    end else begin
      r_qual_cnt   <= w_qual_nxt;
      r_hold_cnt   <= w_hold_nxt;
      r_loss_cnt   <= w_loss_nxt;
      r_lost_count <= w_lost_nxt;
      r_rst_out_n  <= w_rst_out_n_nxt;
      r_ready      <= w_ready_nxt;
    end
  end

  assign rst_out_n  = r_rst_out_n;
  assign ready      = r_ready;
  assign seq_state  = r_state;
  assign lost_count = r_lost_count;

endmodule
